// File: rtl/msrv32_reg_writeback.sv
// msrv32_reg_writeback
// Write-side controller for the integer register file. Merges stage-3
// results (ALU / CSR / PC+4) with load data returning from the data-memory
// interface onto one registered write port, and keeps a scoreboard of
// registers that still wait for load data so hazards can be detected.
module msrv32_reg_writeback #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        s3_valid_in,
  input  logic        s3_wr_en_in,
  input  logic [4:0]  s3_rd_addr_in,
  input  logic [1:0]  s3_wb_sel_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] csr_data_in,
  input  logic [31:0] pc_plus4_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [1:0]  load_byte_off_in,
  input  logic        ms_rdata_valid_in,
  input  logic [31:0] ms_rdata_in,
  output logic        ms_rdata_ready_out,
  output logic        stall_out,
  input  logic [4:0]  rs_1_addr_in,
  input  logic [4:0]  rs_2_addr_in,
  output logic        rs1_busy_out,
  output logic        rs2_busy_out,
  output logic [4:0]  rd_addr_out,
  output logic        wr_en_out,
  output logic [31:0] rd_out
);

  // Queue index width; one extra wrap bit distinguishes full from empty.
  localparam int IDX_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_CSR  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Advance a wrap-bit pointer; handles depths that are not powers of two.
  function automatic logic [IDX_W:0] f_ptr_inc(input logic [IDX_W:0] ptr);
    logic [IDX_W:0] nxt;
    if (ptr[IDX_W-1:0] == IDX_W'(LQ_DEPTH - 1)) begin
      nxt = {~ptr[IDX_W], {IDX_W{1'b0}}};
    end else begin
      nxt = {ptr[IDX_W], ptr[IDX_W-1:0] + IDX_W'(1)};
    end
    return nxt;
  endfunction

  // Select and extend the addressed bytes of a raw load word.
  function automatic logic [31:0] f_load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Pending-load queue storage and pointers
  logic [4:0]     r_lq_rd   [LQ_DEPTH];
  logic [1:0]     r_lq_size [LQ_DEPTH];
  logic           r_lq_uns  [LQ_DEPTH];
  logic [1:0]     r_lq_off  [LQ_DEPTH];
  logic [IDX_W:0] r_wr_ptr;
  logic [IDX_W:0] r_rd_ptr;

  // Scoreboard: bit set while a load to that register is outstanding
  logic [31:0] r_busy;

  // Registered register-file write port
  logic        r_wr_en;
  logic [4:0]  r_rd_addr;
  logic [31:0] r_rd;

  logic        w_write;
  logic        w_is_load;
  logic        w_empty;
  logic        w_full;
  logic        w_rd_busy;
  logic        w_stall;
  logic        w_nonload_go;
  logic        w_push;
  logic        w_ready;
  logic        w_pop;
  logic [4:0]  w_head_rd;
  logic [31:0] w_s3_result;
  logic [31:0] w_load_value;
  logic [31:0] w_busy_nxt;

  assign w_write   = s3_valid_in & s3_wr_en_in;
  assign w_is_load = (s3_wb_sel_in == WB_LOAD);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                     (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  assign w_head_rd = r_lq_rd[r_rd_ptr[IDX_W-1:0]];

  // Hazard/stall decision and port arbitration (non-load results win)
  always_comb begin
    w_rd_busy    = 1'b0;
    w_stall      = 1'b0;
    w_nonload_go = 1'b0;
    w_push       = 1'b0;
    if (s3_rd_addr_in != 5'd0) begin
      w_rd_busy = r_busy[s3_rd_addr_in];
    end else begin
      w_rd_busy = 1'b0;
    end
    if (w_write && w_is_load) begin
      w_stall = w_full | w_rd_busy;
      w_push  = ~w_stall;
    end else if (w_write) begin
      w_stall      = w_rd_busy;
      w_nonload_go = ~w_stall;
    end else begin
      w_stall = 1'b0;
    end
    w_ready = ~w_empty & ~w_nonload_go;
    w_pop   = ms_rdata_valid_in & w_ready;
  end

  // Stage-3 result source selection
  always_comb begin
    w_s3_result = 32'h0000_0000;
    case (s3_wb_sel_in)
      WB_ALU:  w_s3_result = alu_result_in;
      WB_CSR:  w_s3_result = csr_data_in;
      WB_PC4:  w_s3_result = pc_plus4_in;
      default: w_s3_result = 32'h0000_0000;
    endcase
  end

  assign w_load_value = f_load_extract(ms_rdata_in,
                                       r_lq_size[r_rd_ptr[IDX_W-1:0]],
                                       r_lq_uns[r_rd_ptr[IDX_W-1:0]],
                                       r_lq_off[r_rd_ptr[IDX_W-1:0]]);

  // Next scoreboard: retire the accepted head, then mark a newly queued load
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_push && (s3_rd_addr_in != 5'd0)) begin
      w_busy_nxt[s3_rd_addr_in] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Queue pointers, entry storage and scoreboard state
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_busy   <= 32'h0000_0000;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_lq_rd[i]   <= 5'd0;
        r_lq_size[i] <= 2'b00;
        r_lq_uns[i]  <= 1'b0;
        r_lq_off[i]  <= 2'b00;
      end
    end else begin
      r_busy <= w_busy_nxt;
      if (w_push) begin
        r_lq_rd[r_wr_ptr[IDX_W-1:0]]   <= s3_rd_addr_in;
        r_lq_size[r_wr_ptr[IDX_W-1:0]] <= load_size_in;
        r_lq_uns[r_wr_ptr[IDX_W-1:0]]  <= load_unsigned_in;
        r_lq_off[r_wr_ptr[IDX_W-1:0]]  <= load_byte_off_in;
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
    end
  end

  // Register-file write port: one write per cycle, stage-3 result first
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_wr_en   <= 1'b0;
      r_rd_addr <= 5'd0;
      r_rd      <= 32'h0000_0000;
    end else if (w_nonload_go) begin
      r_wr_en   <= (s3_rd_addr_in != 5'd0);
      r_rd_addr <= s3_rd_addr_in;
      r_rd      <= w_s3_result;
    end else if (w_pop) begin
      r_wr_en   <= (w_head_rd != 5'd0);
      r_rd_addr <= w_head_rd;
      r_rd      <= w_load_value;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign stall_out          = w_stall;
  assign ms_rdata_ready_out = w_ready;
  assign rs1_busy_out       = r_busy[rs_1_addr_in];
  assign rs2_busy_out       = r_busy[rs_2_addr_in];
  assign wr_en_out          = r_wr_en;
  assign rd_addr_out        = r_rd_addr;
  assign rd_out             = r_rd;

endmodule

// File: tb/tb_msrv32_reg_writeback.sv
// Testbench for msrv32_reg_writeback: directed scenarios followed by random
// traffic, checked against a queue-based model of the pending loads.
module tb_msrv32_reg_writeback;

  localparam int LQ_DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        s3_valid_in, s3_wr_en_in;
  logic [4:0]  s3_rd_addr_in;
  logic [1:0]  s3_wb_sel_in;
  logic [31:0] alu_result_in, csr_data_in, pc_plus4_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  load_byte_off_in;
  logic        ms_rdata_valid_in;
  logic [31:0] ms_rdata_in;
  logic        ms_rdata_ready_out, stall_out;
  logic [4:0]  rs_1_addr_in, rs_2_addr_in;
  logic        rs1_busy_out, rs2_busy_out;
  logic [4:0]  rd_addr_out;
  logic        wr_en_out;
  logic [31:0] rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rd;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } ld_t;

  ld_t         q[$];
  logic        exp_wr_en = 1'b0;
  logic [4:0]  exp_addr = 5'd0;
  logic [31:0] exp_data = 32'd0;

  msrv32_reg_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .s3_valid_in(s3_valid_in), .s3_wr_en_in(s3_wr_en_in),
    .s3_rd_addr_in(s3_rd_addr_in), .s3_wb_sel_in(s3_wb_sel_in),
    .alu_result_in(alu_result_in), .csr_data_in(csr_data_in),
    .pc_plus4_in(pc_plus4_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .load_byte_off_in(load_byte_off_in),
    .ms_rdata_valid_in(ms_rdata_valid_in), .ms_rdata_in(ms_rdata_in),
    .ms_rdata_ready_out(ms_rdata_ready_out), .stall_out(stall_out),
    .rs_1_addr_in(rs_1_addr_in), .rs_2_addr_in(rs_2_addr_in),
    .rs1_busy_out(rs1_busy_out), .rs2_busy_out(rs2_busy_out),
    .rd_addr_out(rd_addr_out), .wr_en_out(wr_en_out), .rd_out(rd_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A register is busy while some queued load targets it (x0 never is).
  function automatic logic pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Load result from memory semantics: take 1/2/4 bytes starting at the
  // addressed byte lane, then sign- or zero-extend.
  function automatic logic [31:0] model_load(input ld_t e, input logic [31:0] d);
    int     nbytes;
    int     lane;
    longint v;
    nbytes = (e.size == 2'd0) ? 1 : (e.size == 2'd1) ? 2 : 4;
    lane   = (nbytes == 1) ? int'(e.off) : (nbytes == 2) ? ((int'(e.off) >= 2) ? 2 : 0) : 0;
    v = longint'(d) / (longint'(1) << (8 * lane));
    v = v % (longint'(1) << (8 * nbytes));
    if (!e.uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
      v = v - (longint'(1) << (8 * nbytes));
    return v[31:0];
  endfunction

  task automatic set_idle();
    s3_valid_in = 1'b0; s3_wr_en_in = 1'b0; s3_rd_addr_in = 5'd0; s3_wb_sel_in = 2'b00;
    alu_result_in = 32'd0; csr_data_in = 32'd0; pc_plus4_in = 32'd0;
    load_size_in = 2'b00; load_unsigned_in = 1'b0; load_byte_off_in = 2'b00;
    ms_rdata_valid_in = 1'b0; ms_rdata_in = 32'd0;
    rs_1_addr_in = 5'd0; rs_2_addr_in = 5'd0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] v);
    s3_valid_in = 1'b1; s3_wr_en_in = 1'b1; s3_rd_addr_in = rd;
    s3_wb_sel_in = 2'b00; alu_result_in = v;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [1:0] sz, input logic u, input logic [1:0] off);
    s3_valid_in = 1'b1; s3_wr_en_in = 1'b1; s3_rd_addr_in = rd; s3_wb_sel_in = 2'b11;
    load_size_in = sz; load_unsigned_in = u; load_byte_off_in = off;
  endtask

  task automatic set_resp(input logic v, input logic [31:0] d);
    ms_rdata_valid_in = v; ms_rdata_in = d;
  endtask

  task automatic no_s3();
    s3_valid_in = 1'b0; s3_wr_en_in = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check the port.
  task automatic cycle();
    logic w, is_ld, full, hz, e_stall, nl, e_ready;
    ld_t  e;
    #1;
    w       = s3_valid_in & s3_wr_en_in;
    is_ld   = (s3_wb_sel_in == 2'b11);
    full    = (q.size() >= LQ_DEPTH);
    hz      = pending(s3_rd_addr_in);
    e_stall = w && (is_ld ? (full || hz) : hz);
    nl      = w && !is_ld && !e_stall;
    e_ready = (q.size() != 0) && !nl;
    chk("stall", 32'(stall_out), 32'(e_stall));
    chk("ready", 32'(ms_rdata_ready_out), 32'(e_ready));
    chk("rs1_busy", 32'(rs1_busy_out), 32'(pending(rs_1_addr_in)));
    chk("rs2_busy", 32'(rs2_busy_out), 32'(pending(rs_2_addr_in)));
    exp_wr_en = 1'b0;
    if (nl) begin
      exp_wr_en = (s3_rd_addr_in != 5'd0);
      exp_addr  = s3_rd_addr_in;
      exp_data  = (s3_wb_sel_in == 2'b00) ? alu_result_in :
                  (s3_wb_sel_in == 2'b01) ? csr_data_in : pc_plus4_in;
    end else if (ms_rdata_valid_in && e_ready) begin
      e = q.pop_front();
      exp_wr_en = (e.rd != 5'd0);
      exp_addr  = e.rd;
      exp_data  = model_load(e, ms_rdata_in);
    end
    if (w && is_ld && !e_stall) begin
      e.rd = s3_rd_addr_in; e.size = load_size_in;
      e.uns = load_unsigned_in; e.off = load_byte_off_in;
      q.push_back(e);
    end
    @(posedge clk_in); #1;
    chk("wr_en", 32'(wr_en_out), 32'(exp_wr_en));
    if (exp_wr_en) begin
      chk("rd_addr", 32'(rd_addr_out), 32'(exp_addr));
      chk("rd_data", rd_out, exp_data);
    end
  endtask

  // Asynchronous reset with whatever inputs are currently applied.
  task automatic do_reset();
    reset_in = 1'b1;
    #1;
    q.delete();
    chk("rst_wr_en", 32'(wr_en_out), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_out), 32'd0);
    chk("rst_rd_out", rd_out, 32'd0);
    chk("rst_ready", 32'(ms_rdata_ready_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_rs1_busy", 32'(rs1_busy_out), 32'd0);
    chk("rst_rs2_busy", 32'(rs2_busy_out), 32'd0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    exp_wr_en = 1'b0;
  endtask

  initial begin
    set_idle();
    reset_in = 1'b0;
    #2;
    do_reset();

    // ALU write x5
    set_alu(5'd5, 32'h12345678); cycle();
    chk("alu_x5_data", rd_out, 32'h12345678);
    no_s3(); cycle();

    // Signed byte load x7, off 2
    set_load(5'd7, 2'b00, 1'b0, 2'd2); cycle();
    no_s3(); rs_1_addr_in = 5'd7; cycle();
    chk("x7_busy", 32'(rs1_busy_out), 32'd1);
    set_resp(1'b1, 32'h00800000); cycle();
    chk("x7_byte", rd_out, 32'hFFFFFF80);
    set_resp(1'b0, 32'd0); cycle();

    // Queue full: third load stalls; simultaneous push/pop afterwards
    set_load(5'd10, 2'b01, 1'b1, 2'd2); cycle();
    set_load(5'd11, 2'b01, 1'b0, 2'd0); rs_2_addr_in = 5'd11; cycle();
    set_load(5'd12, 2'b10, 1'b0, 2'd0);
    set_resp(1'b1, 32'hBEEF1234); cycle();
    set_resp(1'b1, 32'h0000F00D); cycle();
    set_resp(1'b0, 32'd0); no_s3(); cycle();
    set_resp(1'b1, 32'hCAFEF00D); cycle();
    set_resp(1'b0, 32'd0); cycle();

    // ALU write wins the port over a valid load response
    set_load(5'd13, 2'b00, 1'b1, 2'd3); cycle();
    set_alu(5'd9, 32'hA5A5A5A5); set_resp(1'b1, 32'h7F000000); cycle();
    no_s3(); cycle();
    set_resp(1'b0, 32'd0); cycle();

    // WAW on x7, then a load to x0
    set_load(5'd7, 2'b10, 1'b0, 2'd0); cycle();
    set_alu(5'd7, 32'h00000077); cycle();
    set_resp(1'b1, 32'h11223344); cycle();
    set_resp(1'b0, 32'd0); cycle();
    set_load(5'd0, 2'b10, 1'b0, 2'd0); rs_1_addr_in = 5'd0; cycle();
    no_s3(); set_resp(1'b1, 32'h55555555); cycle();
    set_resp(1'b0, 32'd0); cycle();

    // Reset with two loads pending, then a stray response
    set_load(5'd3, 2'b10, 1'b0, 2'd0); cycle();
    set_load(5'd4, 2'b10, 1'b0, 2'd0); cycle();
    no_s3(); set_resp(1'b1, 32'h99999999);
    do_reset();
    rs_1_addr_in = 5'd3; rs_2_addr_in = 5'd4; cycle();
    set_resp(1'b0, 32'd0); cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      s3_valid_in       = ($urandom_range(0, 3) != 0);
      s3_wr_en_in       = ($urandom_range(0, 7) != 0);
      s3_rd_addr_in     = 5'($urandom_range(0, 5));
      s3_wb_sel_in      = 2'($urandom_range(0, 3));
      alu_result_in     = $urandom;
      csr_data_in       = $urandom;
      pc_plus4_in       = $urandom;
      load_size_in      = 2'($urandom_range(0, 3));
      load_unsigned_in  = 1'($urandom_range(0, 1));
      load_byte_off_in  = 2'($urandom_range(0, 3));
      ms_rdata_valid_in = 1'($urandom_range(0, 1));
      ms_rdata_in       = $urandom;
      rs_1_addr_in      = 5'($urandom_range(0, 7));
      rs_2_addr_in      = 5'($urandom_range(0, 7));
      if (n % 1000 == 999) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
